instr_encoder: RTL

Streaming MIPS instruction encoder and instruction-memory loader. Accepts one symbolic instruction per handshake (mnemonic ID plus register, shift and immediate fields) and packs it into a 32-bit MIPS word. The word uses exactly the op/func encodings the instruction decoder recognises. Each word is written sequentially into instruction memory starting at address 0. The block sits between the test/boot command source and the imem write port, and is the encoding-side counterpart of the control decoder.

---
 rtl/mips_pkg.sv | 70 +++++++
 rtl/instr_pack.sv | 56 +++++
 rtl/instr_encoder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions.
// Holds the symbolic mnemonic IDs accepted by the encoder, the opcode and
// func constants (identical to those the control decoder recognises), the
// instruction field bit positions and small word-assembly helpers.
package mips_pkg;

    // 27 legal mnemonic IDs; anything above MN_JAL is illegal.
    typedef enum logic [4:0] {
        MN_NOP   = 5'd0,
        MN_ADD, MN_ADDU, MN_SUB, MN_SUBU, MN_AND, MN_OR, MN_NOR, MN_SLT,
        MN_SLL, MN_SRL, MN_SRA, MN_JR,
        MN_ANDI, MN_ORI, MN_SLTI, MN_ADDI, MN_ADDIU, MN_BEQ, MN_BNE, MN_LW, MN_SW,
        MN_BGTZ, MN_BGEZ, MN_LUI, MN_J, MN_JAL
    } mnem_e;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BGEZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type func codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // Field LSB positions
    localparam int unsigned OP_LSB = 26;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_LSB = 16;
    localparam int unsigned RD_LSB = 11;
    localparam int unsigned SH_LSB = 6;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return (32'(OP_RTYPE) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) |
               (32'(rd) << RD_LSB) | (32'(sh) << SH_LSB) | 32'(fn);
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return (32'(op) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm);
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return (32'(op) << OP_LSB) | 32'(tgt);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational instruction packer.
// Ports: mnem/rs/rt/rd/shamt/imm in -> 32-bit word and illegal flag out.
// Fields an instruction does not use are dropped; fixed fields (e.g. BGEZ
// rt=1, shift rs=0) are forced here. Illegal IDs produce word 0.
module instr_pack
    import mips_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic [15:0] imm16;
    assign imm16 = imm[15:0];

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (mnem)
            MN_NOP:   word = '0;
            MN_ADD:   word = enc_r(rs, rt, rd, 5'd0, FN_ADD);
            MN_ADDU:  word = enc_r(rs, rt, rd, 5'd0, FN_ADDU);
            MN_SUB:   word = enc_r(rs, rt, rd, 5'd0, FN_SUB);
            MN_SUBU:  word = enc_r(rs, rt, rd, 5'd0, FN_SUBU);
            MN_AND:   word = enc_r(rs, rt, rd, 5'd0, FN_AND);
            MN_OR:    word = enc_r(rs, rt, rd, 5'd0, FN_OR);
            MN_NOR:   word = enc_r(rs, rt, rd, 5'd0, FN_NOR);
            MN_SLT:   word = enc_r(rs, rt, rd, 5'd0, FN_SLT);
            MN_SLL:   word = enc_r(5'd0, rt, rd, shamt, FN_SLL);
            MN_SRL:   word = enc_r(5'd0, rt, rd, shamt, FN_SRL);
            MN_SRA:   word = enc_r(5'd0, rt, rd, shamt, FN_SRA);
            MN_JR:    word = enc_r(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            MN_ANDI:  word = enc_i(OP_ANDI, rs, rt, imm16);
            MN_ORI:   word = enc_i(OP_ORI, rs, rt, imm16);
            MN_SLTI:  word = enc_i(OP_SLTI, rs, rt, imm16);
            MN_ADDI:  word = enc_i(OP_ADDI, rs, rt, imm16);
            MN_ADDIU: word = enc_i(OP_ADDIU, rs, rt, imm16);
            MN_BEQ:   word = enc_i(OP_BEQ, rs, rt, imm16);
            MN_BNE:   word = enc_i(OP_BNE, rs, rt, imm16);
            MN_LW:    word = enc_i(OP_LW, rs, rt, imm16);
            MN_SW:    word = enc_i(OP_SW, rs, rt, imm16);
            MN_BGTZ:  word = enc_i(OP_BGTZ, rs, 5'd0, imm16);
            MN_BGEZ:  word = enc_i(OP_BGEZ, rs, 5'd1, imm16);
            MN_LUI:   word = enc_i(OP_LUI, 5'd0, rt, imm16);
            MN_J:     word = enc_j(OP_J, imm);
            MN_JAL:   word = enc_j(OP_JAL, imm);
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder / imem loader.
// Ports: clk, reset_n (sync, active low); start pulse; cmd_* handshake with
// mnemonic, fields and last flag; imem_we/addr/wdata write port; busy/done
// state flags; sticky err for illegal mnemonics; count of words written.
// A legal command accepted at edge N is written during cycle N+1. count is
// bumped at the accept edge so it already includes the write on the bus;
// imem_addr shows the address of the most recent write.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_mnem,
    input  logic              cmd_last,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_shamt,
    input  logic [25:0]       cmd_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0]       pack_word;
    logic              pack_illegal;
    logic              accept;

    instr_pack u_pack (
        .mnem    (cmd_mnem),
        .rs      (cmd_rs),
        .rt      (cmd_rt),
        .rd      (cmd_rd),
        .shamt   (cmd_shamt),
        .imm     (cmd_imm),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    // count never exceeds CAP, so inequality is the capacity test
    assign cmd_ready = (state_q == S_RUN) && (count_q != CAP);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (pack_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        wdata_d = pack_word;
                        addr_d  = count_q[ADDR_W-1:0];
                        count_d = count_q + 1'b1;
                    end
                    // last and capacity may coincide: one transition, one write
                    if (cmd_last || (count_d == CAP)) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    // A write already registered is dropped while reset is asserted
    assign imem_we    = we_q && reset_n;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign count      = count_q;

endmodule
